// File: rtl/cve2_xif_offload_pkg.sv
// Shared types for the X-IF offload tracker: tracker entries, buffered results
// and a counter-width helper.
package cve2_xif_offload_pkg;

    localparam int unsigned XIF_ID_WIDTH   = 4;
    localparam int unsigned XIF_DATA_WIDTH = 32;
    localparam int unsigned XIF_RD_WIDTH   = 5;

    typedef struct packed {
        logic                    valid;
        logic [XIF_ID_WIDTH-1:0] id;
        logic                    writeback;
        logic                    committed;
    } tracker_entry_t;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0]   id;
        logic [XIF_DATA_WIDTH-1:0] data;
        logic [XIF_RD_WIDTH-1:0]   rd;
        logic                      we;
    } xif_result_t;

    // Bits needed to count 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cve2_xif_result_fifo.sv
// Result FIFO between coprocessor and core writeback; optional same-cycle bypass
// under CVE2_XIF_RESULT_BYPASS_EN. Latency 1 cycle (0 with bypass); push_ready low when full.
module cve2_xif_result_fifo
    import cve2_xif_offload_pkg::*;
#(
    parameter int unsigned RES_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  xif_result_t push_data_i,
    output logic        push_ready_o,
    output logic        pop_valid_o,
    input  logic        pop_ready_i,
    output xif_result_t pop_data_o
);

    localparam int unsigned PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int unsigned CW = cnt_width(RES_DEPTH);

    xif_result_t     mem_q [RES_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            bypass;
    logic            store;
    logic            pop_stored;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (cnt_q == CW'(RES_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign pop_stored = !fifo_empty && pop_ready_i;

`ifdef CVE2_XIF_RESULT_BYPASS_EN
    // A result arriving into an empty FIFO with the core ready skips storage.
    assign bypass       = fifo_empty && push_i && pop_ready_i;
    assign push_ready_o = !fifo_full || pop_ready_i;
    assign pop_valid_o  = !fifo_empty || bypass;
    assign pop_data_o   = bypass ? push_data_i : mem_q[rd_ptr_q];
`else
    assign bypass       = 1'b0;
    assign push_ready_o = !fifo_full;
    assign pop_valid_o  = !fifo_empty;
    assign pop_data_o   = mem_q[rd_ptr_q];
`endif

    assign store = push_i && !bypass;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (store) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (pop_stored) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({store, pop_stored})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cve2_xif_offload_tracker.sv
// X-IF bridge tracking offloaded IDs, registering commits and buffering results (macro CVE2_XIF_RESULT_BYPASS_EN).
// Latency: issue 0 cycles, commit 1 cycle, result 1 cycle (0 with bypass).
// Backpressure: issue stalls on full tracker or duplicate ID; result ready drops when the FIFO is full.
module cve2_xif_offload_tracker
    import cve2_xif_offload_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = XIF_ID_WIDTH,
    parameter int unsigned DATA_WIDTH = XIF_DATA_WIDTH,
    parameter int unsigned NUM_OUT    = 4,
    parameter int unsigned RES_DEPTH  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cpu_issue_valid_i,
    output logic                          cpu_issue_ready_o,
    input  logic [ID_WIDTH-1:0]           cpu_issue_id_i,
    input  logic [31:0]                   cpu_issue_instr_i,
    output logic                          cpu_issue_accept_o,
    output logic                          cpu_issue_writeback_o,
    output logic                          cop_issue_valid_o,
    input  logic                          cop_issue_ready_i,
    output logic [ID_WIDTH-1:0]           cop_issue_id_o,
    output logic [31:0]                   cop_issue_instr_o,
    input  logic                          cop_issue_accept_i,
    input  logic                          cop_issue_writeback_i,
    input  logic                          cpu_commit_valid_i,
    input  logic [ID_WIDTH-1:0]           cpu_commit_id_i,
    input  logic                          cpu_commit_kill_i,
    output logic                          cop_commit_valid_o,
    output logic [ID_WIDTH-1:0]           cop_commit_id_o,
    output logic                          cop_commit_kill_o,
    input  logic                          cop_result_valid_i,
    output logic                          cop_result_ready_o,
    input  logic [ID_WIDTH-1:0]           cop_result_id_i,
    input  logic [DATA_WIDTH-1:0]         cop_result_data_i,
    input  logic [4:0]                    cop_result_rd_i,
    input  logic                          cop_result_we_i,
    output logic                          cpu_result_valid_o,
    input  logic                          cpu_result_ready_i,
    output logic [ID_WIDTH-1:0]           cpu_result_id_o,
    output logic [DATA_WIDTH-1:0]         cpu_result_data_o,
    output logic [4:0]                    cpu_result_rd_o,
    output logic                          cpu_result_we_o,
    output logic [$clog2(NUM_OUT+1)-1:0]  outstanding_o,
    output logic                          err_o
);

    localparam int unsigned CW = cnt_width(NUM_OUT);
    localparam int unsigned IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    tracker_entry_t  trk_q [NUM_OUT];
    tracker_entry_t  trk_d [NUM_OUT];
    logic [CW-1:0]   valid_cnt;
    logic            full;
    logic            dup;
    logic            issue_ok;
    logic            alloc;
    logic [IW-1:0]   alloc_idx;
    logic            cmt_hit;
    logic [IW-1:0]   cmt_idx;
    logic            res_hit;
    logic [IW-1:0]   res_idx;
    logic            res_hs;
    logic            kill_same;
    logic            res_push;
    logic            err_set;
    logic            err_q;
    logic            fifo_push_ready;
    xif_result_t     res_in;
    xif_result_t     res_out;
    logic            cmt_vld_q;
    logic [ID_WIDTH-1:0] cmt_id_q;
    logic            cmt_kill_q;

    // ID lookups; descending scan so the lowest matching/free index wins.
    always_comb begin
        valid_cnt = '0;
        dup       = 1'b0;
        cmt_hit   = 1'b0;
        cmt_idx   = '0;
        res_hit   = 1'b0;
        res_idx   = '0;
        alloc_idx = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            valid_cnt = valid_cnt + CW'(trk_q[i].valid);
            if (trk_q[i].valid) begin
                if (trk_q[i].id == cpu_issue_id_i) dup = 1'b1;
                if (trk_q[i].id == cpu_commit_id_i) begin
                    cmt_hit = 1'b1;
                    cmt_idx = IW'(i);
                end
                if (trk_q[i].id == cop_result_id_i) begin
                    res_hit = 1'b1;
                    res_idx = IW'(i);
                end
            end else begin
                alloc_idx = IW'(i);
            end
        end
    end

    assign full     = (valid_cnt == CW'(NUM_OUT));
    assign issue_ok = !rst_i && !full && !dup;

    assign cop_issue_valid_o     = cpu_issue_valid_i && issue_ok;
    assign cpu_issue_ready_o     = cop_issue_ready_i && issue_ok;
    assign cop_issue_id_o        = cpu_issue_id_i;
    assign cop_issue_instr_o     = cpu_issue_instr_i;
    assign cpu_issue_accept_o    = cop_issue_accept_i;
    assign cpu_issue_writeback_o = cop_issue_writeback_i;

    assign alloc = cpu_issue_valid_i && cpu_issue_ready_o && cop_issue_accept_i;

    assign cop_result_ready_o = !rst_i && fifo_push_ready;
    assign res_hs             = cop_result_valid_i && cop_result_ready_o;

    // A kill for the same ID in the same cycle swallows the result silently.
    assign kill_same = cpu_commit_valid_i && cpu_commit_kill_i && cmt_hit &&
                       res_hs && res_hit && (cmt_idx == res_idx);
    assign res_push  = res_hs && res_hit && trk_q[res_idx].committed && !kill_same;

    assign err_set = (cpu_commit_valid_i && !cmt_hit) ||
                     (res_hs && !res_hit) ||
                     (res_hs && res_hit && !trk_q[res_idx].committed && !kill_same);

    always_comb begin
        trk_d = trk_q;
        if (alloc) begin
            trk_d[alloc_idx].valid     = 1'b1;
            trk_d[alloc_idx].id        = cpu_issue_id_i;
            trk_d[alloc_idx].writeback = cop_issue_writeback_i;
            trk_d[alloc_idx].committed = 1'b0;
        end
        if (cpu_commit_valid_i && cmt_hit) begin
            if (cpu_commit_kill_i) trk_d[cmt_idx].valid     = 1'b0;
            else                   trk_d[cmt_idx].committed = 1'b1;
        end
        if (res_hs && res_hit) begin
            trk_d[res_idx].valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                trk_q[i] <= '0;
            end
            err_q      <= 1'b0;
            cmt_vld_q  <= 1'b0;
            cmt_id_q   <= '0;
            cmt_kill_q <= 1'b0;
        end else begin
            trk_q      <= trk_d;
            err_q      <= err_q | err_set;
            cmt_vld_q  <= cpu_commit_valid_i;
            cmt_id_q   <= cpu_commit_id_i;
            cmt_kill_q <= cpu_commit_kill_i;
        end
    end

    assign cop_commit_valid_o = cmt_vld_q;
    assign cop_commit_id_o    = cmt_id_q;
    assign cop_commit_kill_o  = cmt_kill_q;
    assign outstanding_o      = valid_cnt;
    assign err_o              = err_q;

    assign res_in = '{id: cop_result_id_i, data: cop_result_data_i,
                      rd: cop_result_rd_i, we: cop_result_we_i};

    cve2_xif_result_fifo #(
        .RES_DEPTH(RES_DEPTH)
    ) u_res_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (res_push),
        .push_data_i (res_in),
        .push_ready_o(fifo_push_ready),
        .pop_valid_o (cpu_result_valid_o),
        .pop_ready_i (cpu_result_ready_i),
        .pop_data_o  (res_out)
    );

    assign cpu_result_id_o   = res_out.id;
    assign cpu_result_data_o = res_out.data;
    assign cpu_result_rd_o   = res_out.rd;
    assign cpu_result_we_o   = res_out.we;

endmodule

// File: tb/tb_cve2_xif_offload_tracker.sv
// Randomized bench for cve2_xif_offload_tracker, checked against an ID-set and
// result-queue reference model.
module tb_cve2_xif_offload_tracker;

    localparam int NUM_OUT   = 4;
    localparam int RES_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_issue_valid, cpu_issue_ready, cpu_issue_accept, cpu_issue_writeback;
    logic [3:0]  cpu_issue_id;
    logic [31:0] cpu_issue_instr;
    logic        cop_issue_valid, cop_issue_ready, cop_issue_accept, cop_issue_writeback;
    logic [3:0]  cop_issue_id;
    logic [31:0] cop_issue_instr;
    logic        cpu_commit_valid, cpu_commit_kill;
    logic [3:0]  cpu_commit_id;
    logic        cop_commit_valid, cop_commit_kill;
    logic [3:0]  cop_commit_id;
    logic        cop_result_valid, cop_result_ready, cop_result_we;
    logic [3:0]  cop_result_id;
    logic [31:0] cop_result_data;
    logic [4:0]  cop_result_rd;
    logic        cpu_result_valid, cpu_result_ready, cpu_result_we;
    logic [3:0]  cpu_result_id;
    logic [31:0] cpu_result_data;
    logic [4:0]  cpu_result_rd;
    logic [2:0]  outstanding;
    logic        err;

    always #5 clk = ~clk;

    cve2_xif_offload_tracker #(
        .ID_WIDTH(4), .DATA_WIDTH(32), .NUM_OUT(NUM_OUT), .RES_DEPTH(RES_DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_issue_valid_i(cpu_issue_valid), .cpu_issue_ready_o(cpu_issue_ready),
        .cpu_issue_id_i(cpu_issue_id), .cpu_issue_instr_i(cpu_issue_instr),
        .cpu_issue_accept_o(cpu_issue_accept), .cpu_issue_writeback_o(cpu_issue_writeback),
        .cop_issue_valid_o(cop_issue_valid), .cop_issue_ready_i(cop_issue_ready),
        .cop_issue_id_o(cop_issue_id), .cop_issue_instr_o(cop_issue_instr),
        .cop_issue_accept_i(cop_issue_accept), .cop_issue_writeback_i(cop_issue_writeback),
        .cpu_commit_valid_i(cpu_commit_valid), .cpu_commit_id_i(cpu_commit_id),
        .cpu_commit_kill_i(cpu_commit_kill),
        .cop_commit_valid_o(cop_commit_valid), .cop_commit_id_o(cop_commit_id),
        .cop_commit_kill_o(cop_commit_kill),
        .cop_result_valid_i(cop_result_valid), .cop_result_ready_o(cop_result_ready),
        .cop_result_id_i(cop_result_id), .cop_result_data_i(cop_result_data),
        .cop_result_rd_i(cop_result_rd), .cop_result_we_i(cop_result_we),
        .cpu_result_valid_o(cpu_result_valid), .cpu_result_ready_i(cpu_result_ready),
        .cpu_result_id_o(cpu_result_id), .cpu_result_data_o(cpu_result_data),
        .cpu_result_rd_o(cpu_result_rd), .cpu_result_we_o(cpu_result_we),
        .outstanding_o(outstanding), .err_o(err)
    );

    // Reference model: set of outstanding IDs with a committed flag, result queue.
    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } res_t;

    bit         m_out [16];
    bit         m_com [16];
    res_t       m_fifo [$];
    bit         m_err;
    bit         pc_v, pc_k;
    logic [3:0] pc_id;
    bit         m_after_rst;

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(m_out[i]);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_out[i] = 1'b0;
            m_com[i] = 1'b0;
        end
        m_fifo.delete();
        m_err = 1'b0;
        pc_v = 1'b0; pc_k = 1'b0; pc_id = '0;
    endtask

    task automatic idle();
        rst = 1'b0;
        cpu_issue_valid = 1'b0; cpu_issue_id = '0; cpu_issue_instr = '0;
        cop_issue_ready = 1'b1; cop_issue_accept = 1'b1; cop_issue_writeback = 1'b0;
        cpu_commit_valid = 1'b0; cpu_commit_id = '0; cpu_commit_kill = 1'b0;
        cop_result_valid = 1'b0; cop_result_id = '0; cop_result_data = '0;
        cop_result_rd = '0; cop_result_we = 1'b0;
        cpu_result_ready = 1'b1;
    endtask

    // Called just after inputs are driven on the falling edge: check, advance model, clock.
    task automatic step();
        int   cnt;
        bit   ok, rrdy, ihs, rhs, kill_same;
        bit   o_out [16];
        bit   o_com [16];
        res_t r;
        #1;
        cnt  = model_count();
        ok   = !rst && (cnt != NUM_OUT) && !m_out[cpu_issue_id];
        rrdy = !rst && (m_fifo.size() < RES_DEPTH);
        check("cop_issue_valid", cop_issue_valid, cpu_issue_valid && ok);
        check("cpu_issue_ready", cpu_issue_ready, cop_issue_ready && ok);
        check("issue_passthru", {cop_issue_id, cop_issue_instr, cpu_issue_accept, cpu_issue_writeback},
              {cpu_issue_id, cpu_issue_instr, cop_issue_accept, cop_issue_writeback});
        check("cop_result_ready", cop_result_ready, rrdy);
        check("cpu_result_valid", cpu_result_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0)
            check("cpu_result_payload", {cpu_result_id, cpu_result_data, cpu_result_rd, cpu_result_we},
                  {m_fifo[0].id, m_fifo[0].data, m_fifo[0].rd, m_fifo[0].we});
        else if (m_after_rst)
            check("reset_payload", {cpu_result_id, cpu_result_data, cpu_result_rd, cpu_result_we}, '0);
        check("outstanding", outstanding, cnt);
        check("err", err, m_err);
        check("cop_commit", {cop_commit_valid, cop_commit_id, cop_commit_kill}, {pc_v, pc_id, pc_k});

        m_after_rst = rst;
        if (rst) begin
            model_clear();
        end else begin
            o_out = m_out;
            o_com = m_com;
            ihs = cpu_issue_valid && cop_issue_ready && ok;
            rhs = cop_result_valid && rrdy;
            kill_same = cpu_commit_valid && cpu_commit_kill && rhs &&
                        (cpu_commit_id == cop_result_id) && o_out[cpu_commit_id];
            if (ihs && cop_issue_accept) begin
                m_out[cpu_issue_id] = 1'b1;
                m_com[cpu_issue_id] = 1'b0;
            end
            if (cpu_commit_valid) begin
                if (!o_out[cpu_commit_id])  m_err = 1'b1;
                else if (cpu_commit_kill)   m_out[cpu_commit_id] = 1'b0;
                else                        m_com[cpu_commit_id] = 1'b1;
            end
            if (m_fifo.size() > 0 && cpu_result_ready) void'(m_fifo.pop_front());
            if (rhs) begin
                if (!o_out[cop_result_id]) begin
                    m_err = 1'b1;
                end else begin
                    m_out[cop_result_id] = 1'b0;
                    if (!kill_same) begin
                        if (o_com[cop_result_id]) begin
                            r.id = cop_result_id; r.data = cop_result_data;
                            r.rd = cop_result_rd; r.we = cop_result_we;
                            m_fifo.push_back(r);
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end
            end
            pc_v = cpu_commit_valid; pc_id = cpu_commit_id; pc_k = cpu_commit_kill;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_issue(input logic [3:0] id);
        idle();
        cpu_issue_valid = 1'b1; cpu_issue_id = id; cpu_issue_instr = $urandom;
        step();
    endtask

    task automatic do_commit(input logic [3:0] id, input bit kill);
        idle();
        cpu_commit_valid = 1'b1; cpu_commit_id = id; cpu_commit_kill = kill;
        step();
    endtask

    task automatic set_result(input logic [3:0] id);
        cop_result_valid = 1'b1; cop_result_id = id; cop_result_data = $urandom;
        cop_result_rd = 5'($urandom); cop_result_we = 1'($urandom);
    endtask

    task automatic random_cycle(input int p_iss, input int p_res, input int p_rdy);
        logic [3:0] uncom [$];
        logic [3:0] com [$];
        for (int i = 0; i < 16; i++) begin
            if (m_out[i] && !m_com[i]) uncom.push_back(4'(i));
            if (m_out[i] &&  m_com[i]) com.push_back(4'(i));
        end
        idle();
        rst                 = ($urandom_range(0, 299) == 0);
        cpu_issue_valid     = ($urandom_range(0, 99) < p_iss);
        cpu_issue_id        = 4'($urandom_range(0, 7));
        cpu_issue_instr     = $urandom;
        cop_issue_ready     = ($urandom_range(0, 3) != 0);
        cop_issue_accept    = ($urandom_range(0, 7) != 0);
        cop_issue_writeback = 1'($urandom);
        cpu_commit_valid    = ($urandom_range(0, 99) < 35);
        cpu_commit_kill     = ($urandom_range(0, 4) == 0);
        if (uncom.size() > 0 && $urandom_range(0, 19) != 0)
            cpu_commit_id = uncom[$urandom_range(0, uncom.size() - 1)];
        else
            cpu_commit_id = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 99) < p_res) begin
            if (com.size() > 0 && $urandom_range(0, 19) != 0)
                set_result(com[$urandom_range(0, com.size() - 1)]);
            else
                set_result(4'($urandom_range(0, 15)));
        end
        if (cpu_commit_valid && cpu_commit_kill && $urandom_range(0, 2) == 0)
            set_result(cpu_commit_id);
        cpu_result_ready = ($urandom_range(0, 99) < p_rdy);
        step();
    endtask

    initial begin
        idle();
        model_clear();
        m_after_rst = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Issue/commit of ID 3, commit pulse, then result delivery.
        do_issue(4'd3);
        do_commit(4'd3, 1'b0);
        idle(); step();
        idle(); set_result(4'd3); step();
        idle(); step();

        // Fill the tracker, then hold ID 5 while ID 0 completes.
        do_issue(4'd0); do_issue(4'd1); do_issue(4'd2); do_issue(4'd4);
        do_issue(4'd5);
        do_commit(4'd0, 1'b0);
        idle(); cpu_issue_valid = 1'b1; cpu_issue_id = 4'd5; set_result(4'd0); step();
        do_issue(4'd5);

        // Duplicate ID 2 stalls.
        do_issue(4'd2);

        // Kill and result for ID 1 in the same cycle.
        idle(); cpu_commit_valid = 1'b1; cpu_commit_id = 4'd1; cpu_commit_kill = 1'b1;
        set_result(4'd1); step();

        // Back-pressure: two committed results with the core not ready.
        do_commit(4'd2, 1'b0);
        do_commit(4'd4, 1'b0);
        do_commit(4'd5, 1'b0);
        idle(); cpu_result_ready = 1'b0; set_result(4'd2); step();
        idle(); cpu_result_ready = 1'b0; set_result(4'd4); step();
        idle(); cpu_result_ready = 1'b0; set_result(4'd5); step();
        idle(); step(); idle(); step();
        idle(); set_result(4'd5); step();
        idle(); step();

        // Unknown ID result, then a mid-stream reset.
        idle(); set_result(4'd7); step();
        do_issue(4'd6);
        idle(); step();
        idle(); rst = 1'b1; step();
        idle(); step();

        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 750; c++) begin
                case (ph)
                    0: random_cycle(70, 40, 80);
                    1: random_cycle(80, 10, 80);
                    2: random_cycle(50, 60, 10);
                    default: random_cycle(50, 50, 50);
                endcase
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/cve2_xif_offload_tracker.md
# cve2_xif_offload_tracker

Buffered, parametrised X-IF bridge between the CVE2 core-side X-IF issue/commit/result channels and a coprocessor. It tracks up to `NUM_OUT` offloaded instructions by ID and registers the commit channel toward the coprocessor. It buffers coprocessor results in a `RES_DEPTH` FIFO, so the coprocessor is not back-pressured by the core's writeback timing. It drops results of killed instructions and flags protocol violations. The block sits in `core-v-mini-mcu` between the CPU wrapper and the X-IF coprocessor ports.

## Interface
Parameters:
- `ID_WIDTH`, 4, instruction ID width
- `DATA_WIDTH`, 32, result data width
- `NUM_OUT`, 4, max outstanding tracked instructions (≥1)
- `RES_DEPTH`, 2, result FIFO depth (≥1)

Ports:
- `clk_i` in 1: the single clock
- `rst_i` in 1: reset, **synchronous, active-high**
- `cpu_issue_valid_i` in 1 / `cpu_issue_ready_o` out 1: core issue handshake
- `cpu_issue_id_i` in ID_WIDTH / `cpu_issue_instr_i` in 32: issued instruction
- `cpu_issue_accept_o` / `cpu_issue_writeback_o` out 1: coprocessor response, passed through
- `cop_issue_valid_o` out 1 / `cop_issue_ready_i` in 1: coprocessor issue handshake
- `cop_issue_id_o` out ID_WIDTH / `cop_issue_instr_o` out 32: forwarded instruction
- `cop_issue_accept_i` / `cop_issue_writeback_i` in 1: coprocessor response
- `cpu_commit_valid_i` in 1, `cpu_commit_id_i` in ID_WIDTH, `cpu_commit_kill_i` in 1: core commit
- `cop_commit_valid_o` out 1, `cop_commit_id_o` out ID_WIDTH, `cop_commit_kill_o` out 1: registered commit
- `cop_result_valid_i` in 1 / `cop_result_ready_o` out 1: coprocessor result handshake
- `cop_result_id_i` in ID_WIDTH, `cop_result_data_i` in DATA_WIDTH, `cop_result_rd_i` in 5, `cop_result_we_i` in 1: result payload
- `cpu_result_valid_o` out 1 / `cpu_result_ready_i` in 1: core result handshake
- `cpu_result_id_o`, `cpu_result_data_o`, `cpu_result_rd_o`, `cpu_result_we_o` out: FIFO head payload
- `outstanding_o` out `$clog2(NUM_OUT+1)`: tracked entry count
- `err_o` out 1: sticky protocol error

## Operation
- Tracker: `NUM_OUT` entries, each holding {valid, id, writeback, committed}.
- **Issue path**
  - `full` = (count == `NUM_OUT`). It is computed from registered state, so an entry freed in the same cycle does not unblock issue.
  - `dup` = `cpu_issue_id_i` matches a valid entry.
  - `cop_issue_valid_o` = `cpu_issue_valid_i & !full & !dup`.
  - `cpu_issue_ready_o` = `cop_issue_ready_i & !full & !dup`.
  - Instr, id, accept and writeback are passed through combinationally.
- **Allocation:** on an issue handshake with `cop_issue_accept_i`=1, the lowest free entry is allocated. A rejected instruction allocates nothing.
- **Commit**
  - The commit is registered by one cycle toward the coprocessor.
  - Matching entry with kill=0: the `committed` flag is set.
  - Matching entry with kill=1: the entry is freed.
  - No matching entry: `err_o` is set and the commit is still forwarded.
- **Result**
  - `cop_result_ready_o` = !fifo_full.
  - On a handshake with a matching committed entry: the payload is pushed into the FIFO and the entry is freed.
  - On a handshake with no matching entry, or an uncommitted entry: the payload is dropped and `err_o` is set. An uncommitted entry is also freed.
- **Simultaneous kill-commit and result for the same ID:** kill wins. The result is consumed and dropped, the entry is freed, and no error is raised.
- Allocate and free in the same cycle are both applied; `outstanding_o` counts net.
- FIFO pops on `cpu_result_valid_o & cpu_result_ready_i`. Push and pop in the same cycle when full is not possible, because ready is low.

## Timing
- Issue: zero-latency combinational pass-through.
- Commit: 1-cycle latency. `cop_commit_valid_o` is a one-cycle pulse per input commit.
- Result: 1-cycle latency from the coprocessor handshake to `cpu_result_valid_o`, unless bypass is enabled (see Configuration).
- Registered outputs clear on the clock edge where `rst_i`=1:
  - `cop_commit_*` = 0
  - `cpu_result_valid_o` = 0 and payload = 0
  - `outstanding_o` = 0
  - `err_o` = 0
  - tracker and FIFO emptied
- While `rst_i`=1, the combinational `cpu_issue_ready_o`, `cop_issue_valid_o` and `cop_result_ready_o` are forced to 0.
- `err_o` clears only on reset.
- FIFO read/write pointers wrap modulo `RES_DEPTH`; the count is separate.

## Configuration
- Macro `CVE2_XIF_RESULT_BYPASS_EN`.
- **Defined:** when the FIFO is empty and `cpu_result_ready_i`=1, a valid committed result passes combinationally to `cpu_*` in the same cycle without being stored. `cop_result_ready_o` also asserts when the FIFO is full but a pop happens that cycle.
- **Undefined:** results are always registered (1-cycle latency), and ready depends on !fifo_full only.

## Structure
- Package `cve2_xif_offload_pkg` holds:
  - `tracker_entry_t` (valid, id, writeback, committed)
  - `xif_result_t` (id, data, rd, we)
  - a `cnt_width` helper function
- Sub-module `cve2_xif_result_fifo`: parametrised `RES_DEPTH` FIFO of `xif_result_t`, with the optional bypass under the macro.
- The tracker CAM and the control logic stay in the top module.

## Test plan
- **Issue and commit:** issue ID 3 with accept=1, then commit ID 3 with kill=0 → `outstanding_o`=1, and `cop_commit_valid_o` pulses one cycle later with id 3.
- **Full tracker:** issue 4 accepted IDs with `NUM_OUT`=4, then attempt ID 5 → `cpu_issue_ready_o`=0 and `cop_issue_valid_o`=0 until a result for ID 0 is accepted.
- **Duplicate ID:** issue ID 2 twice → the second issue stalls until the ID 2 result frees its entry.
- **Kill vs. result:** kill-commit ID 1 in the same cycle as the result for ID 1 → result consumed, FIFO unchanged, `err_o`=0, `outstanding_o` decrements.
- **Back-pressure:** hold `cpu_result_ready_i`=0 and accept 2 results (`RES_DEPTH`=2) → `cop_result_ready_o`=0; release it → results are delivered in order and ready returns high.
- **Unknown ID and reset:** result for unknown ID 7 → dropped and `err_o`=1; then assert `rst_i` for one cycle mid-stream → all outputs return to the reset values above.
